// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and freezes the five pipeline
// latches for cache misses, load-use, redirects and the halt drain.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        mem_atomic,
  input  logic        ex_dren,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        redirect,
  input  logic        mem_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        idex_freeze,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT_DRAIN,
    HALTED
  } state_e;

  state_e      state_q, state_d, st;
  logic [1:0]  drain_q, drain_d;
  logic        halt_q, halt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        mreq, mem_wait, load_use;

  // Atomics already raise mem_ren/mem_wen, so they wait on dhit like any op.
  logic unused_atomic;
  assign unused_atomic = mem_atomic;

  assign mreq     = mem_ren | mem_wen;
  assign mem_wait = mreq & ~dhit;
  assign load_use = ex_dren && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    st          = RST ? RUN : state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    idex_freeze = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    priority case (1'b1)
      (st == HALTED): begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        idex_freeze = 1'b1;
      end
      (st == HALT_DRAIN): begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      mem_wait: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        idex_freeze = 1'b1;
      end
      redirect: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      load_use: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      (!ihit): begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else if (mem_halt) begin
          state_d = HALT_DRAIN;
          drain_d = 2'd0;
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) state_d = RUN;
      end
      HALT_DRAIN: begin
        if (drain_q == 2'd1) state_d = HALTED;
        else drain_d = drain_q + 2'd1;
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halt_d      = halt_q | (state_d == HALTED);
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q == RUN || state_q == MEM_WAIT) &&
        stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      drain_q     <= 2'd0;
      halt_q      <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Output vector o = {pc,ifid_en,ifid_fl,idex_en,idex_fl,frz,exmem_en,exmem_fl,memwb}.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, mem_ren, mem_wen, mem_atomic;
  logic        ex_dren, id_uses_rt, redirect, mem_halt;
  logic [4:0]  ex_rd, id_rs, id_rt;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        idex_freeze, exmem_en, exmem_flush, memwb_en, halt;
  logic [15:0] stall_cnt;
  logic [8:0]  o;

  int errors = 0;
  int checks = 0;

  localparam logic [8:0] NORMAL = 9'b110100101;
  localparam logic [8:0] LU_M   = 9'b110010101;
  localparam logic [8:0] LU_E   = 9'b000010101;
  localparam logic [8:0] FRZ_M  = 9'b110101101;
  localparam logic [8:0] FRZ_E  = 9'b000001000;
  localparam logic [8:0] RD_M   = 9'b101010101;
  localparam logic [8:0] RD_E   = 9'b101010101;
  localparam logic [8:0] IM_M   = 9'b101110101;
  localparam logic [8:0] IM_E   = 9'b001100101;
  localparam logic [8:0] DR_M   = 9'b101010011;
  localparam logic [8:0] DR_E   = 9'b001010011;
  localparam logic [8:0] HALTED = 9'b000001000;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_atomic(mem_atomic),
    .ex_dren(ex_dren), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .redirect(redirect), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .idex_freeze(idex_freeze), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  assign o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
              idex_freeze, exmem_en, exmem_flush, memwb_en};

  always #5 CLK = ~CLK;

  task automatic idle();
    ihit = 1; dhit = 1; mem_ren = 0; mem_wen = 0; mem_atomic = 0;
    ex_dren = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    redirect = 0; mem_halt = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    step();
    RST = 0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1;
    #1;
    checks++;
    if (o !== NORMAL) begin
      errors++; $display("FAIL rst_comb o=%b exp=%b", o, NORMAL);
    end
    step();
    step();
    RST = 0;
    checks++;
    if (halt !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_regs halt=%b cnt=%0d exp 0/0", halt, stall_cnt);
    end
    checks++;
    if (o !== NORMAL) begin
      errors++; $display("FAIL rst_normal o=%b exp=%b", o, NORMAL);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_dren = 1; ex_rd = 5; id_rs = 5; #1;
    checks++;
    if ((o & LU_M) !== LU_E) begin
      errors++; $display("FAIL lu_rs o=%b exp=%b", o & LU_M, LU_E);
    end
    ex_rd = 0; id_rs = 0; #1;
    checks++;
    if (o !== NORMAL) begin
      errors++; $display("FAIL lu_r0 o=%b exp=%b", o, NORMAL);
    end
    ex_rd = 9; id_rs = 3; id_rt = 9; id_uses_rt = 1; #1;
    checks++;
    if ((o & LU_M) !== LU_E) begin
      errors++; $display("FAIL lu_rt o=%b exp=%b", o & LU_M, LU_E);
    end
    id_uses_rt = 0; #1;
    checks++;
    if (o !== NORMAL) begin
      errors++; $display("FAIL lu_rt_unused o=%b exp=%b", o, NORMAL);
    end
    ex_dren = 0; ex_rd = 3; #1;
    checks++;
    if (o !== NORMAL) begin
      errors++; $display("FAIL lu_noload o=%b exp=%b", o, NORMAL);
    end
    idle();
  endtask

  task automatic test_data_miss();
    do_reset();
    mem_ren = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ((o & FRZ_M) !== FRZ_E) begin
        errors++; $display("FAIL miss_frz%0d o=%b exp=%b", i, o & FRZ_M, FRZ_E);
      end
      step();
    end
    dhit = 1; #1;
    checks++;
    if (o !== NORMAL || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL miss_done o=%b cnt=%0d exp=%b/3", o, stall_cnt, NORMAL);
    end
    step();
    mem_ren = 0; #1;
    checks++;
    if (o !== NORMAL || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL miss_after o=%b cnt=%0d exp=%b/3", o, stall_cnt, NORMAL);
    end
    mem_wen = 1; mem_atomic = 1; dhit = 0; #1;
    checks++;
    if ((o & FRZ_M) !== FRZ_E) begin
      errors++; $display("FAIL atomic_frz o=%b exp=%b", o & FRZ_M, FRZ_E);
    end
    step();
    dhit = 1; #1;
    checks++;
    if (o !== NORMAL || stall_cnt !== 16'd4) begin
      errors++; $display("FAIL atomic_done o=%b cnt=%0d exp=%b/4", o, stall_cnt, NORMAL);
    end
    step();
    idle();
  endtask

  task automatic test_redirect();
    do_reset();
    redirect = 1; ex_dren = 1; ex_rd = 7; id_rs = 7; ihit = 0; #1;
    checks++;
    if ((o & RD_M) !== RD_E) begin
      errors++; $display("FAIL redir_lu o=%b exp=%b", o & RD_M, RD_E);
    end
    mem_ren = 1; dhit = 0; #1;
    checks++;
    if ((o & FRZ_M) !== FRZ_E) begin
      errors++; $display("FAIL redir_miss o=%b exp=%b", o & FRZ_M, FRZ_E);
    end
    idle();
    ihit = 0; #1;
    checks++;
    if ((o & IM_M) !== IM_E) begin
      errors++; $display("FAIL imiss o=%b exp=%b", o & IM_M, IM_E);
    end
    ex_dren = 1; ex_rd = 4; id_rs = 4; #1;
    checks++;
    if ((o & LU_M) !== LU_E) begin
      errors++; $display("FAIL lu_over_imiss o=%b exp=%b", o & LU_M, LU_E);
    end
    idle();
  endtask

  task automatic test_halt();
    do_reset();
    mem_halt = 1; #1;
    checks++;
    if (o !== NORMAL) begin
      errors++; $display("FAIL halt_entry o=%b exp=%b", o, NORMAL);
    end
    step();
    mem_halt = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ((o & DR_M) !== DR_E || halt !== 1'b0) begin
        errors++; $display("FAIL drain%0d o=%b halt=%b exp=%b/0", i, o & DR_M, halt, DR_E);
      end
      step();
    end
    checks++;
    if (o !== HALTED || halt !== 1'b1 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL halted o=%b halt=%b cnt=%0d exp=%b/1/0", o, halt, stall_cnt, HALTED);
    end
    ihit = 0; mem_ren = 1; dhit = 0; redirect = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (halt !== 1'b1 || o !== HALTED || stall_cnt !== 16'd0) begin
        errors++; $display("FAIL halt_hold%0d halt=%b o=%b cnt=%0d", i, halt, o, stall_cnt);
      end
    end
    idle();
    RST = 1; #1;
    checks++;
    if (o !== NORMAL) begin
      errors++; $display("FAIL halt_rst_comb o=%b exp=%b", o, NORMAL);
    end
    step();
    RST = 0;
    checks++;
    if (halt !== 1'b0 || o !== NORMAL) begin
      errors++; $display("FAIL halt_rst halt=%b o=%b exp 0/%b", halt, o, NORMAL);
    end
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    ihit = 0;
    repeat (4) step();
    ihit = 1; mem_ren = 1; dhit = 0;
    repeat (3) step();
    checks++;
    if (stall_cnt !== 16'd7 || (o & FRZ_M) !== FRZ_E) begin
      errors++; $display("FAIL pre_rst cnt=%0d o=%b exp 7/%b", stall_cnt, o & FRZ_M, FRZ_E);
    end
    RST = 1;
    step();
    RST = 0; mem_ren = 0; dhit = 1; #1;
    checks++;
    if (stall_cnt !== 16'd0 || o !== NORMAL) begin
      errors++; $display("FAIL mid_rst cnt=%0d o=%b exp 0/%b", stall_cnt, o, NORMAL);
    end
    mem_halt = 1;
    step();
    mem_halt = 0;
    checks++;
    if ((o & DR_M) !== DR_E) begin
      errors++; $display("FAIL mid_rst_run o=%b exp=%b", o & DR_M, DR_E);
    end
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    ihit = 0;
    repeat (65534) @(posedge CLK);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre cnt=%h exp=fffe", stall_cnt);
    end
    repeat (6) step();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat cnt=%h exp=ffff", stall_cnt);
    end
    step();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold cnt=%h exp=ffff", stall_cnt);
    end
    idle();
  endtask

  initial begin
    RST = 1;
    idle();
    test_reset();
    test_load_use();
    test_data_miss();
    test_redirect();
    test_halt();
    test_reset_mid_miss();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
